// File: rtl/quicksort_main.sv
// quicksort_main
// Sorts a 10-entry signed byte array held in internal RAM A into ascending
// order. Each start copies the initial-value ROM B into A and then runs an
// iterative (explicit stack) Lomuto quicksort in place. When the sort is
// finished, done_port pulses for one cycle.
//
// Ports
//   clock, reset                 rising-edge clock, asynchronous active-low reset
//   start_port                   start pulse, honoured only in IDLE
//   S_oe_ram/S_we_ram [1:0]      per-channel slave read/write enables
//   S_addr_ram [13:0]            channel k address = [7k+6:7k]
//   S_Wdata_ram [15:0]           channel k write byte = [8k+7:8k]
//   S_data_ram_size [7:0]        channel k access size = [4k+3:4k]; only 8 is decoded
//   M_Rdata_ram, M_DataRdy       master bus inputs (not used)
//   done_port                    one-cycle completion pulse
//   Sout_Rdata_ram [15:0]        per-channel read data, 0 on lanes without a read ack
//   Sout_DataRdy [1:0]           per-channel ack, one cycle after an accepted request
//   Mout_*                       master bus outputs, tied to 0
//
// Slave channel 0 maps RAM A and channel 1 maps ROM B. Channel 0 writes take
// effect only in IDLE. Channel 1 writes are acknowledged but not stored.
module quicksort_main #(
  parameter int MEM_var_28860_28869 = 32,
  parameter int MEM_var_29137_28866 = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_port,
  input  logic [1:0]  S_oe_ram,
  input  logic [1:0]  S_we_ram,
  input  logic [13:0] S_addr_ram,
  input  logic [15:0] S_Wdata_ram,
  input  logic [7:0]  S_data_ram_size,
  input  logic [15:0] M_Rdata_ram,
  input  logic [1:0]  M_DataRdy,
  output logic        done_port,
  output logic [15:0] Sout_Rdata_ram,
  output logic [1:0]  Sout_DataRdy,
  output logic [1:0]  Mout_oe_ram,
  output logic [1:0]  Mout_we_ram,
  output logic [13:0] Mout_addr_ram,
  output logic [15:0] Mout_Wdata_ram,
  output logic [7:0]  Mout_data_ram_size
);

  localparam int         N      = 10;
  localparam logic [3:0] LAST   = 4'(N - 1);
  localparam logic [6:0] BASE_A = 7'(MEM_var_28860_28869);
  localparam logic [6:0] BASE_B = 7'(MEM_var_29137_28866);

  typedef enum logic [2:0] {IDLE, COPY, POP, PART, PUSH, DONE} state_t;

  state_t state, state_nx;

  logic signed [7:0] mem_a  [0:N-1];
  logic        [3:0] stk_lo [0:N-1];
  logic        [3:0] stk_hi [0:N-1];
  logic        [3:0] sp, idx, lo, hi, i, j;
  logic signed [7:0] pivot;

  function automatic logic signed [7:0] rom_b(input logic [3:0] k);
    case (k)
      4'd0:    rom_b = 8'h05;
      4'd1:    rom_b = 8'hFD;
      4'd2:    rom_b = 8'h0C;
      4'd3:    rom_b = 8'h00;
      4'd4:    rom_b = 8'h07;
      4'd5:    rom_b = 8'h07;
      4'd6:    rom_b = 8'h80;
      4'd7:    rom_b = 8'h7F;
      4'd8:    rom_b = 8'h01;
      4'd9:    rom_b = 8'h02;
      default: rom_b = 8'h00;
    endcase
  endfunction

  // The stack top is read combinationally so that a pop and the range test finish in one cycle.
  logic [3:0] top, top_lo, top_hi;
  logic       lt_pivot, push_hi, push_lo;

  assign top      = (sp == 4'd0) ? 4'd0 : sp - 4'd1;
  assign top_lo   = stk_lo[top];
  assign top_hi   = stk_hi[top];
  assign lt_pivot = mem_a[j] < pivot;
  assign push_hi  = (i + 4'd1) < hi;
  assign push_lo  = i > lo;

  // Slave address decode. The offset is forced to 0 on a miss, so array
  // reads always use a valid index.
  logic [6:0]        ch_addr [0:1];
  logic [6:0]        ch_base [0:1];
  logic [3:0]        ch_off  [0:1];
  logic [1:0]        hit, rd;
  logic signed [7:0] rbyte   [0:1];
  logic              wr_a;

  always_comb begin
    hit = 2'b00;
    rd  = 2'b00;
    for (int k = 0; k < 2; k++) begin
      ch_addr[k] = S_addr_ram[7*k +: 7];
      ch_base[k] = (k == 0) ? BASE_A : BASE_B;
      hit[k]     = (S_oe_ram[k] | S_we_ram[k]) &&
                   (ch_addr[k] >= ch_base[k]) &&
                   (ch_addr[k] < ch_base[k] + 7'(N)) &&
                   (S_data_ram_size[4*k +: 4] == 4'd8);
      ch_off[k]  = hit[k] ? 4'(ch_addr[k] - ch_base[k]) : 4'd0;
      rd[k]      = hit[k] & S_oe_ram[k];
    end
    rbyte[0] = mem_a[ch_off[0]];
    rbyte[1] = rom_b(ch_off[1]);
  end

  assign wr_a = hit[0] & S_we_ram[0] & ~S_oe_ram[0] & (state == IDLE);

  // Stage p0 -> p1: register the ack and the read data sampled at request time.
  logic [1:0]  vld_p1;
  logic [15:0] rdata_p1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_p1   <= 2'b00;
      rdata_p1 <= 16'h0000;
    end else begin
      vld_p1   <= hit;
      rdata_p1 <= {rd[1] ? rbyte[1] : 8'sh00, rd[0] ? rbyte[0] : 8'sh00};
    end
  end

  assign Sout_DataRdy   = vld_p1;
  assign Sout_Rdata_ram = rdata_p1;

  // Control state: FSM register and stack pointer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sp    <= 4'd0;
    end else begin
      state <= state_nx;
      case (state)
        COPY:    if (idx == LAST) sp <= 4'd1;
        POP:     if (sp != 4'd0) sp <= sp - 4'd1;
        PUSH:    sp <= sp + {3'b000, push_hi} + {3'b000, push_lo};
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx  = state;
    done_port = 1'b0;
    case (state)
      IDLE: if (start_port) state_nx = COPY;
      COPY: if (idx == LAST) state_nx = POP;
      POP: begin
        if (sp == 4'd0)          state_nx = DONE;
        else if (top_lo < top_hi) state_nx = PART;
        else                     state_nx = POP;
      end
      PART: if (j == hi) state_nx = PUSH;
      PUSH: state_nx = POP;
      DONE: begin
        done_port = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: RAM A, the stack entries and the partition indices.
  // (lo, i-1) is pushed after (i+1, hi), so the left sub-range is popped first.
  always_ff @(posedge clock) begin
    if (wr_a) mem_a[ch_off[0]] <= S_Wdata_ram[7:0];
    case (state)
      IDLE: idx <= 4'd0;
      COPY: begin
        mem_a[idx] <= rom_b(idx);
        idx        <= idx + 4'd1;
        if (idx == LAST) begin
          stk_lo[0] <= 4'd0;
          stk_hi[0] <= LAST;
        end
      end
      POP: begin
        if (sp != 4'd0) begin
          lo    <= top_lo;
          hi    <= top_hi;
          pivot <= mem_a[top_hi];
          i     <= top_lo;
          j     <= top_lo;
        end
      end
      PART: begin
        if (j == hi) begin
          mem_a[i]  <= mem_a[hi];
          mem_a[hi] <= mem_a[i];
        end else begin
          if (lt_pivot) begin
            mem_a[i] <= mem_a[j];
            mem_a[j] <= mem_a[i];
            i        <= i + 4'd1;
          end
          j <= j + 4'd1;
        end
      end
      PUSH: begin
        if (push_hi) begin
          stk_lo[sp] <= i + 4'd1;
          stk_hi[sp] <= hi;
        end
        if (push_lo) begin
          stk_lo[sp + {3'b000, push_hi}] <= lo;
          stk_hi[sp + {3'b000, push_hi}] <= i - 4'd1;
        end
      end
      default: ;
    endcase
  end

  assign Mout_oe_ram        = 2'b00;
  assign Mout_we_ram        = 2'b00;
  assign Mout_addr_ram      = 14'h0000;
  assign Mout_Wdata_ram     = 16'h0000;
  assign Mout_data_ram_size = 8'h00;

  logic unused_inputs;
  assign unused_inputs = ^{M_Rdata_ram, M_DataRdy, S_Wdata_ram[15:8]};

endmodule

// File: tb/tb_quicksort_main.sv
// Testbench for quicksort_main. It drives slave-bus requests from a table,
// queues the expected ack and read data in a scoreboard, and checks them the
// cycle they are due. Done pulses and the master bus are monitored throughout.
module tb_quicksort_main;

  logic        clock;
  logic        reset;
  logic        start_port;
  logic [1:0]  S_oe_ram, S_we_ram;
  logic [13:0] S_addr_ram;
  logic [15:0] S_Wdata_ram;
  logic [7:0]  S_data_ram_size;
  logic [15:0] M_Rdata_ram;
  logic [1:0]  M_DataRdy;
  logic        done_port;
  logic [15:0] Sout_Rdata_ram;
  logic [1:0]  Sout_DataRdy;
  logic [1:0]  Mout_oe_ram, Mout_we_ram;
  logic [13:0] Mout_addr_ram;
  logic [15:0] Mout_Wdata_ram;
  logic [7:0]  Mout_data_ram_size;

  quicksort_main dut (
    .clock              (clock),
    .reset              (reset),
    .start_port         (start_port),
    .S_oe_ram           (S_oe_ram),
    .S_we_ram           (S_we_ram),
    .S_addr_ram         (S_addr_ram),
    .S_Wdata_ram        (S_Wdata_ram),
    .S_data_ram_size    (S_data_ram_size),
    .M_Rdata_ram        (M_Rdata_ram),
    .M_DataRdy          (M_DataRdy),
    .done_port          (done_port),
    .Sout_Rdata_ram     (Sout_Rdata_ram),
    .Sout_DataRdy       (Sout_DataRdy),
    .Mout_oe_ram        (Mout_oe_ram),
    .Mout_we_ram        (Mout_we_ram),
    .Mout_addr_ram      (Mout_addr_ram),
    .Mout_Wdata_ram     (Mout_Wdata_ram),
    .Mout_data_ram_size (Mout_data_ram_size)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct packed {
    logic        ch;
    logic        oe;
    logic        we;
    logic [6:0]  addr;
    logic [7:0]  wdata;
    logic [3:0]  size;
    logic [1:0]  rdy;
    logic [15:0] data;
  } vec_t;

  typedef struct {
    int          due;
    logic [1:0]  rdy;
    logic [15:0] data;
    int          ch;
    logic [6:0]  addr;
  } exp_t;

  localparam int NV = 22;
  vec_t tbl [0:NV-1];
  vec_t midw;
  logic [7:0] sorted [0:9] = '{8'h80, 8'hFD, 8'h00, 8'h01, 8'h02,
                               8'h05, 8'h07, 8'h07, 8'h0C, 8'h7F};

  exp_t sbq [$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   width_err = 0;
  bit   prev_done = 1'b0;
  bit   mout_bad = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    exp_t e;
    if (done_port === 1'b1) begin
      done_cnt++;
      if (prev_done) width_err++;
    end
    prev_done = (done_port === 1'b1);
    if (|{Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size} !== 1'b0)
      mout_bad = 1'b1;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      chk($sformatf("ack ch%0d addr %0d", e.ch, e.addr), {30'd0, Sout_DataRdy}, {30'd0, e.rdy});
      chk($sformatf("rdata ch%0d addr %0d", e.ch, e.addr), {16'd0, Sout_Rdata_ram}, {16'd0, e.data});
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bus_idle();
    S_oe_ram        = 2'b00;
    S_we_ram        = 2'b00;
    S_addr_ram      = 14'h0000;
    S_Wdata_ram     = 16'h0000;
    S_data_ram_size = 8'h00;
  endtask

  task automatic req(input vec_t v);
    exp_t e;
    bus_idle();
    if (v.ch) begin
      S_oe_ram[1]          = v.oe;
      S_we_ram[1]          = v.we;
      S_addr_ram[13:7]     = v.addr;
      S_Wdata_ram[15:8]    = v.wdata;
      S_data_ram_size[7:4] = v.size;
    end else begin
      S_oe_ram[0]          = v.oe;
      S_we_ram[0]          = v.we;
      S_addr_ram[6:0]      = v.addr;
      S_Wdata_ram[7:0]     = v.wdata;
      S_data_ram_size[3:0] = v.size;
    end
    e.due  = cyc + 1;
    e.rdy  = v.rdy;
    e.data = v.data;
    e.ch   = int'(v.ch);
    e.addr = v.addr;
    sbq.push_back(e);
    tick();
    bus_idle();
  endtask

  task automatic run_table();
    for (int n = 0; n < NV; n++) req(tbl[n]);
    repeat (2) tick();
  endtask

  task automatic run_sort(input bit restart, input bit midwrite);
    int snap;
    bit seen;
    snap = done_cnt;
    seen = 1'b0;
    start_port = 1'b1;
    tick();
    start_port = 1'b0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      if (restart && c == 4) begin
        start_port = 1'b1;
        tick();
        start_port = 1'b0;
      end else if (midwrite && c == 12) begin
        req(midw);
      end else begin
        tick();
      end
      if (done_cnt != snap) seen = 1'b1;
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
    repeat (30) tick();
    chk("done_count", done_cnt - snap, 32'd1);
    chk("done_width", width_err, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    for (int k = 0; k < 10; k++)
      tbl[k] = '{1'b0, 1'b1, 1'b0, 7'(32 + k), 8'h00, 4'd8, 2'b01, {8'h00, sorted[k]}};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 7'd38, 8'h00, 4'd8, 2'b10, 16'h8000};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 7'd32, 8'h00, 4'd8, 2'b10, 16'h0500};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 7'd31, 8'h00, 4'd8, 2'b00, 16'h0000};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 7'd42, 8'h00, 4'd8, 2'b00, 16'h0000};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 7'd32, 8'h00, 4'd0, 2'b00, 16'h0000};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 7'd32, 8'h00, 4'd4, 2'b00, 16'h0000};
    tbl[16] = '{1'b1, 1'b1, 1'b0, 7'd42, 8'h00, 4'd8, 2'b00, 16'h0000};
    tbl[17] = '{1'b1, 1'b0, 1'b1, 7'd34, 8'hAA, 4'd8, 2'b10, 16'h0000};
    tbl[18] = '{1'b1, 1'b1, 1'b0, 7'd34, 8'h00, 4'd8, 2'b10, 16'h0C00};
    tbl[19] = '{1'b0, 1'b1, 1'b1, 7'd32, 8'h11, 4'd8, 2'b01, 16'h0080};
    tbl[20] = '{1'b0, 1'b1, 1'b0, 7'd32, 8'h00, 4'd8, 2'b01, 16'h0080};
    tbl[21] = '{1'b0, 1'b0, 1'b1, 7'd42, 8'h33, 4'd8, 2'b00, 16'h0000};
    midw    = '{1'b0, 1'b0, 1'b1, 7'd33, 8'h55, 4'd8, 2'b01, 16'h0000};

    reset       = 1'b0;
    start_port  = 1'b0;
    M_Rdata_ram = 16'h0000;
    M_DataRdy   = 2'b00;
    bus_idle();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;

    chk("rst_done", {31'd0, done_port}, 32'd0);
    chk("rst_ack", {30'd0, Sout_DataRdy}, 32'd0);
    chk("rst_rdata", {16'd0, Sout_Rdata_ram}, 32'd0);
    chk("rst_mout", {31'd0, |{Mout_oe_ram, Mout_we_ram, Mout_addr_ram,
                              Mout_Wdata_ram, Mout_data_ram_size}}, 32'd0);
    repeat (5) tick();
    chk("idle_no_done", done_cnt, 32'd0);

    run_sort(1'b0, 1'b0);
    run_table();

    req('{1'b0, 1'b0, 1'b1, 7'd33, 8'h55, 4'd8, 2'b01, 16'h0000});
    req('{1'b0, 1'b1, 1'b0, 7'd33, 8'h00, 4'd8, 2'b01, 16'h0055});
    tick();

    run_sort(1'b1, 1'b1);
    run_table();

    snap = done_cnt;
    start_port = 1'b1;
    tick();
    start_port = 1'b0;
    repeat (14) tick();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    repeat (300) tick();
    chk("no_done_after_reset", done_cnt - snap, 32'd0);

    run_sort(1'b0, 1'b0);
    run_table();

    repeat (3) tick();
    chk("mout_zero", {31'd0, mout_bad}, 32'd0);
    chk("scoreboard_drained", sbq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
